// File: rtl/ym_audio_pkg.sv
// Shared constants and types for the YM audio output stages.
// Default mixing weights keep the full-scale sum within an 8-bit level.
package ym_audio_pkg;

  localparam int LEVEL_W    = 8;
  localparam int DEF_BEEP_W = 160;
  localparam int DEF_TAPE_W = 48;
  localparam int DEF_EAR_W  = 32;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

endpackage

// File: rtl/sd_mod1.sv
// First-order sigma-delta modulator: the carry of acc+level is the output bit.
// dsm_out is registered, so it lags level by one cycle; no backpressure.
module sd_mod1
  import ym_audio_pkg::*;
(
  input  logic               clk350,
  input  logic               reset,
  input  logic [LEVEL_W-1:0] level,
  output logic               dsm_out
);

  logic [LEVEL_W-1:0] acc;
  logic [LEVEL_W:0]   sum;

  // The carry fires exactly level times per 256 cycles at constant level.
  assign sum = {1'b0, acc} + {1'b0, level};

  always_ff @(posedge clk350 or negedge reset) begin
    if (!reset) begin
      acc     <= '0;
      dsm_out <= 1'b0;
    end else begin
      acc     <= sum[LEVEL_W-1:0];
      dsm_out <= sum[LEVEL_W];
    end
  end

endmodule

// File: rtl/beeper_sd_dac.sv
// Beeper/tape/EAR mixer: sync, activity FSM with idle decay, slew limiter, 1-bit DSM.
// Level follows target at most SLEW_STEP per tick; dsm_out lags level by one cycle.
module beeper_sd_dac
  import ym_audio_pkg::*;
#(
  parameter int BEEP_W      = DEF_BEEP_W,
  parameter int TAPE_W      = DEF_TAPE_W,
  parameter int EAR_W       = DEF_EAR_W,
  parameter int SLEW_DIV    = 4,
  parameter int SLEW_STEP   = 1,
  parameter int IDLE_CYCLES = 65536
)(
  input  logic               clk350,
  input  logic               reset,
  input  logic               beeper,
  input  logic               tapeout,
  input  logic               ear_in,
  input  logic               mute,
  output logic               dsm_out,
  output logic [LEVEL_W-1:0] level,
  output logic               active
);

  generate
    if (BEEP_W + TAPE_W + EAR_W > 255) begin : g_bad_weights
      $error("beeper_sd_dac: BEEP_W + TAPE_W + EAR_W must not exceed 255");
    end
    if (SLEW_DIV < 1 || SLEW_STEP < 1 || SLEW_STEP > 255 || IDLE_CYCLES < 2) begin : g_bad_params
      $error("beeper_sd_dac: SLEW_DIV, SLEW_STEP or IDLE_CYCLES out of range");
    end
  endgenerate

  localparam int PW = (SLEW_DIV > 1) ? $clog2(SLEW_DIV) : 1;
  localparam int IW = $clog2(IDLE_CYCLES);

  localparam logic [PW-1:0]      PRESC_LAST = PW'(SLEW_DIV - 1);
  localparam logic [IW-1:0]      IDLE_LAST  = IW'(IDLE_CYCLES - 1);
  localparam logic [LEVEL_W:0]   STEP9      = (LEVEL_W+1)'(SLEW_STEP);
  localparam logic [LEVEL_W-1:0] W_BEEP     = LEVEL_W'(BEEP_W);
  localparam logic [LEVEL_W-1:0] W_TAPE     = LEVEL_W'(TAPE_W);
  localparam logic [LEVEL_W-1:0] W_EAR      = LEVEL_W'(EAR_W);

  logic [2:0]         sync1;
  logic [2:0]         s;
  logic [2:0]         s_prev;
  logic               chg;
  state_e             state;
  logic [IW-1:0]      idle_cnt;
  logic [PW-1:0]      presc;
  logic               tick;
  logic [LEVEL_W-1:0] target;
  logic               up;
  logic [LEVEL_W:0]   diff;
  logic [LEVEL_W:0]   step;
  logic [LEVEL_W:0]   level_nxt;

  // s = {beeper, tapeout, ear} after two flops; s_prev gives edge detection.
  always_ff @(posedge clk350 or negedge reset) begin
    if (!reset) begin
      sync1  <= '0;
      s      <= '0;
      s_prev <= '0;
    end else begin
      sync1  <= {beeper, tapeout, ear_in};
      s      <= sync1;
      s_prev <= s;
    end
  end

  assign chg = (s != s_prev);

  always_ff @(posedge clk350 or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      idle_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          idle_cnt <= '0;
          if (chg) state <= ACTIVE;
        end
        ACTIVE: begin
          // A fresh input change always beats the terminal count.
          if (chg) begin
            idle_cnt <= '0;
          end else if (idle_cnt == IDLE_LAST) begin
            state    <= IDLE;
            idle_cnt <= '0;
          end else begin
            idle_cnt <= idle_cnt + IW'(1);
          end
        end
        default: begin
          state    <= IDLE;
          idle_cnt <= '0;
        end
      endcase
    end
  end

  assign active = (state == ACTIVE);

  always_comb begin
    target = '0;
    if (!mute && state == ACTIVE) begin
      target = (s[2] ? W_BEEP : '0) + (s[1] ? W_TAPE : '0) + (s[0] ? W_EAR : '0);
    end
  end

  always_ff @(posedge clk350 or negedge reset) begin
    if (!reset) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  assign tick = (presc == PRESC_LAST);

  // 9-bit distance and step so the move is clamped to the target, never past it.
  always_comb begin
    up        = (target > level);
    diff      = up ? ({1'b0, target} - {1'b0, level}) : ({1'b0, level} - {1'b0, target});
    step      = (diff > STEP9) ? STEP9 : diff;
    level_nxt = up ? ({1'b0, level} + step) : ({1'b0, level} - step);
  end

  always_ff @(posedge clk350 or negedge reset) begin
    if (!reset) begin
      level <= '0;
    end else if (tick) begin
      level <= level_nxt[LEVEL_W-1:0];
    end
  end

  sd_mod1 u_mod (
    .clk350  (clk350),
    .reset   (reset),
    .level   (level),
    .dsm_out (dsm_out)
  );

endmodule

// File: tb/tb_beeper_sd_dac.sv
// Directed bench for beeper_sd_dac: ramp, idle decay, chg-vs-terminal race, mute, reset.
// A second instance with a 64 beeper weight checks the modulator ones density.
module tb_beeper_sd_dac;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       beeper, tapeout, ear_in, mute;
  logic       dsm_out, active;
  logic [7:0] level;
  logic       d_beeper;
  logic       d_dsm, d_active;
  logic [7:0] d_level;

  int cyc    = 0;
  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  beeper_sd_dac #(
    .SLEW_DIV(1), .SLEW_STEP(16), .IDLE_CYCLES(16)
  ) dut (
    .clk350(clk), .reset(rst_n), .beeper(beeper), .tapeout(tapeout),
    .ear_in(ear_in), .mute(mute), .dsm_out(dsm_out), .level(level), .active(active)
  );

  beeper_sd_dac #(
    .BEEP_W(64), .SLEW_DIV(1), .SLEW_STEP(16), .IDLE_CYCLES(4096)
  ) dens (
    .clk350(clk), .reset(rst_n), .beeper(d_beeper), .tapeout(1'b0),
    .ear_in(1'b0), .mute(1'b0), .dsm_out(d_dsm), .level(d_level), .active(d_active)
  );

  // Advance to the falling edge that follows rising edge number e.
  task automatic wait_edge(input int e);
    while (cyc < e) @(negedge clk);
  endtask

  task automatic test_reset();
    int bad;
    rst_n = 1'b0;
    beeper = 1'($urandom); tapeout = 1'($urandom); ear_in = 1'($urandom); mute = 1'($urandom);
    d_beeper = 1'($urandom);
    repeat (5) @(negedge clk);
    n_chk++; if (dsm_out !== 1'b0) $display("FAIL rst_dsm got=%b exp=0", dsm_out); else n_pass++;
    n_chk++; if (level !== 8'd0) $display("FAIL rst_level got=%0d exp=0", level); else n_pass++;
    n_chk++; if (active !== 1'b0) $display("FAIL rst_active got=%b exp=0", active); else n_pass++;
    beeper = 0; tapeout = 0; ear_in = 0; mute = 0; d_beeper = 0;
    rst_n = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (level !== 8'd0 || dsm_out !== 1'b0 || active !== 1'b0) bad++;
    end
    n_chk++; if (bad !== 0) $display("FAIL rst_quiet nonzero_cycles=%0d exp=0", bad); else n_pass++;
  endtask

  task automatic test_density();
    int d, ones, gaps_bad, last;
    d = cyc;
    d_beeper = 1'b1;
    wait_edge(d + 20);
    n_chk++; if (d_level !== 8'd64) $display("FAIL dens_level got=%0d exp=64", d_level); else n_pass++;
    ones = 0; gaps_bad = 0; last = -1;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (d_dsm === 1'b1) begin
        ones++;
        if (last >= 0 && (i - last) != 4) gaps_bad++;
        last = i;
      end
    end
    n_chk++; if (ones !== 64) $display("FAIL dens_ones got=%0d exp=64", ones); else n_pass++;
    n_chk++; if (gaps_bad !== 0) $display("FAIL dens_spacing bad_gaps=%0d exp=0", gaps_bad); else n_pass++;
  endtask

  task automatic test_beeper_ramp();
    int d;
    d = cyc;
    beeper = 1'b1;
    wait_edge(d + 2);
    n_chk++; if (active !== 1'b0) $display("FAIL act_early got=%b exp=0", active); else n_pass++;
    wait_edge(d + 3);
    n_chk++; if (active !== 1'b1) $display("FAIL act_rise got=%b exp=1", active); else n_pass++;
    n_chk++; if (level !== 8'd0) $display("FAIL ramp_start got=%0d exp=0", level); else n_pass++;
    for (int k = 1; k <= 10; k++) begin
      wait_edge(d + 3 + k);
      n_chk++; if (level !== 8'(16 * k)) $display("FAIL ramp_up k=%0d got=%0d exp=%0d", k, level, 16 * k); else n_pass++;
    end
    wait_edge(d + 15);
    n_chk++; if (level !== 8'd160) $display("FAIL ramp_hold got=%0d exp=160", level); else n_pass++;
    d = cyc;
    tapeout = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      wait_edge(d + 2 + k);
      n_chk++; if (level !== 8'(160 + 16 * k)) $display("FAIL tape_up k=%0d got=%0d exp=%0d", k, level, 160 + 16 * k); else n_pass++;
    end
    wait_edge(d + 7);
    n_chk++; if (level !== 8'd208) $display("FAIL tape_hold got=%0d exp=208", level); else n_pass++;
  endtask

  task automatic test_idle();
    int d;
    d = cyc;
    tapeout = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      wait_edge(d + 2 + k);
      n_chk++; if (level !== 8'(208 - 16 * k)) $display("FAIL tape_down k=%0d got=%0d exp=%0d", k, level, 208 - 16 * k); else n_pass++;
    end
    wait_edge(d + 18);
    n_chk++; if (active !== 1'b1) $display("FAIL idle_early got=%b exp=1", active); else n_pass++;
    wait_edge(d + 19);
    n_chk++; if (active !== 1'b0) $display("FAIL idle_drop got=%b exp=0", active); else n_pass++;
    n_chk++; if (level !== 8'd160) $display("FAIL idle_lvl0 got=%0d exp=160", level); else n_pass++;
    for (int k = 1; k <= 10; k++) begin
      wait_edge(d + 19 + k);
      n_chk++; if (level !== 8'(160 - 16 * k)) $display("FAIL idle_decay k=%0d got=%0d exp=%0d", k, level, 160 - 16 * k); else n_pass++;
    end
  endtask

  task automatic test_simultaneous();
    int d;
    d = cyc;
    ear_in = 1'b1;
    @(negedge clk);
    ear_in = 1'b0;
    wait_edge(d + 3);
    n_chk++; if (active !== 1'b1) $display("FAIL sim_act got=%b exp=1", active); else n_pass++;
    wait_edge(d + 13);
    n_chk++; if (level !== 8'd160) $display("FAIL sim_base got=%0d exp=160", level); else n_pass++;
    // Last chg lands at edge d+4, so the terminal-count cycle precedes edge d+20.
    wait_edge(d + 17);
    ear_in = 1'b1;
    wait_edge(d + 20);
    n_chk++; if (active !== 1'b1) $display("FAIL sim_hold got=%b exp=1", active); else n_pass++;
    n_chk++; if (level !== 8'd176) $display("FAIL sim_step1 got=%0d exp=176", level); else n_pass++;
    wait_edge(d + 21);
    n_chk++; if (level !== 8'd192) $display("FAIL sim_target got=%0d exp=192", level); else n_pass++;
    wait_edge(d + 35);
    n_chk++; if (active !== 1'b1) $display("FAIL sim_restart got=%b exp=1", active); else n_pass++;
    wait_edge(d + 36);
    n_chk++; if (active !== 1'b0) $display("FAIL sim_drop got=%b exp=0", active); else n_pass++;
  endtask

  task automatic test_mute_reset();
    int d, r;
    wait_edge(cyc + 14);
    d = cyc;
    ear_in = 1'b0;
    wait_edge(d + 3);
    n_chk++; if (active !== 1'b1) $display("FAIL mute_act got=%b exp=1", active); else n_pass++;
    wait_edge(d + 9);
    n_chk++; if (level !== 8'd96) $display("FAIL mute_start got=%0d exp=96", level); else n_pass++;
    mute = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      wait_edge(d + 9 + k);
      n_chk++; if (level !== 8'(96 - 16 * k)) $display("FAIL mute_ramp k=%0d got=%0d exp=%0d", k, level, 96 - 16 * k); else n_pass++;
    end
    n_chk++; if (active !== 1'b1) $display("FAIL mute_active got=%b exp=1", active); else n_pass++;
    mute = 1'b0;
    wait_edge(d + 18);
    n_chk++; if (level !== 8'd48) $display("FAIL pre_reset got=%0d exp=48", level); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_chk++; if (level !== 8'd0) $display("FAIL arst_level got=%0d exp=0", level); else n_pass++;
    n_chk++; if (dut.u_mod.acc !== 8'd0) $display("FAIL arst_acc got=%0d exp=0", dut.u_mod.acc); else n_pass++;
    n_chk++; if (dsm_out !== 1'b0) $display("FAIL arst_dsm got=%b exp=0", dsm_out); else n_pass++;
    n_chk++; if (active !== 1'b0) $display("FAIL arst_active got=%b exp=0", active); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    r = cyc;
    wait_edge(r + 3);
    n_chk++; if (active !== 1'b1) $display("FAIL post_rst_act got=%b exp=1", active); else n_pass++;
    wait_edge(r + 4);
    n_chk++; if (level !== 8'd16) $display("FAIL post_rst_lvl got=%0d exp=16", level); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_density();
    test_beeper_ramp();
    test_idle();
    test_simultaneous();
    test_mute_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/beeper_sd_dac.md
# beeper_sd_dac

Downstream audio stage for the beeper and tapeout bits produced by the port-#FE decoder in the dual-YM2149 CPLD design. It synchronises beeper, tapeout and the external EAR input and mixes them into an 8-bit weighted level. The level is slew-limited to suppress clicks, decays to zero after a period of inactivity so no DC is held across the speaker, and is rendered as a 1-bit first-order sigma-delta stream that drives the speaker RC filter. It runs on the same 3.5 MHz clock as the decoder.

## Interface
Parameters:
- BEEP_W, 160: level contribution of beeper=1
- TAPE_W, 48: level contribution of tapeout=1
- EAR_W, 32: level contribution of ear_in=1
- SLEW_DIV, 4: clk350 cycles per slew tick, ≥1
- SLEW_STEP, 1: maximum level change per tick, 1..255
- IDLE_CYCLES, 65536: unchanged-input cycles before idle decay (~18.7 ms), ≥2

Ports:
- clk350  in  1  3.5 MHz system clock; all state on its rising edge
- reset  in  1  asynchronous, active-low
- beeper  in  1  beeper bit from decoder
- tapeout  in  1  tapeout bit from decoder
- ear_in  in  1  tape input, asynchronous
- mute  in  1  forces target level 0
- dsm_out  out  1  sigma-delta audio bit
- level  out  8  current slewed level
- active  out  1  1 while in ACTIVE state

## Operation
- Reset (async, reset=0): all sync flops, prescaler, idle counter, accumulator, level and dsm_out go to 0. State goes to IDLE, so active=0.
- Sync: each of beeper, tapeout and ear_in passes through a 2-FF synchroniser; s = {b,t,e} are the second-stage outputs. s_prev holds s delayed by one cycle. chg = (s != s_prev).
- FSM, two states:
  - IDLE→ACTIVE on chg.
  - ACTIVE→IDLE when idle_cnt == IDLE_CYCLES-1 and !chg.
  - In ACTIVE, chg clears idle_cnt to 0; otherwise idle_cnt increments.
  - In IDLE, idle_cnt holds 0.
  - chg wins over terminal count on the same cycle.
- Target (combinational):
  - 0 if mute or state==IDLE.
  - Otherwise b·BEEP_W + t·TAPE_W + e·EAR_W.
  - Elaboration check: BEEP_W + TAPE_W + EAR_W ≤ 255.
- Slew: the prescaler counts 0..SLEW_DIV-1 freely and tick is asserted at SLEW_DIV-1. On a tick, level moves toward target by min(SLEW_STEP, |target−level|). Level never overshoots target; arithmetic is 9-bit to avoid wrap.
- Modulator: {c, acc[7:0]} = acc + level, computed each cycle. acc ← sum[7:0], dsm_out ← c (registered). The ones density of dsm_out equals level/256 exactly over any 256-cycle window while level is constant.
- Mute does not affect FSM or idle_cnt.

## Timing
- Input edge sampled at rising edge n:
  - s changes at edge n+1 (second sync stage).
  - chg is high during cycle n+1.
  - active=1 from edge n+2.
  - target changes in the same cycle as the FSM update.
- level changes at the first tick after target changes, at most SLEW_DIV cycles later.
- dsm_out lags level by 1 cycle.
- Idle: with the last chg seen at cycle k, active falls at edge k+IDLE_CYCLES. level then ramps to 0 at SLEW_STEP per tick.
- Reset mid-ramp takes effect immediately and asynchronously; after release the first tick is SLEW_DIV cycles later.

## Structure
- Shared package ym_audio_pkg:
  - LEVEL_W=8
  - default BEEP_W/TAPE_W/EAR_W
  - typedef of the two-state FSM enum (IDLE, ACTIVE)
- Sub-module sd_mod1: accumulator plus registered carry, with ports clk350, reset, level[7:0], dsm_out.
- The synchronisers, prescaler, idle counter, FSM and slew logic live in the top module.

## Test plan
Bench overrides: SLEW_DIV=1, SLEW_STEP=16, IDLE_CYCLES=16.
- Reset: assert reset with random inputs → dsm_out=0, level=0, active=0. Release with inputs 0 → all remain 0 for 100 cycles.
- Beeper rise at edge 0 → active=1 at edge 2. level increases 16/cycle to exactly 160 with no overshoot. Adding tapeout=1 then raises level to 208.
- Density: hold level at 64 → dsm_out is 1 on exactly 64 of every 256 cycles, spaced one every 4.
- Idle: hold beeper=1 with no further changes → active drops 16 cycles after the last chg; level ramps 160→0 in 10 cycles.
- Simultaneous event: toggle ear_in on the cycle idle_cnt=15 → active stays 1, idle_cnt=0, level target becomes 192.
- Mute and mid-ramp reset: assert mute at level 96 → level ramps to 0 while active stays 1. Pulse reset low mid-ramp → level, acc and dsm_out are 0 at once.
